pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
Central hazard and sequencing controller for the 5-stage segmented RISC-V core.
- Resolves conditional branches from the MEM-stage signals of the EX/MEM register: branch, func3, ALU result and zero.
- Issues the PC redirect and squashes the wrong-path instructions.
- Detects load-use hazards between the EX and ID stages and holds the front end for a programmable number of cycles.
- Keeps taken-branch and stall performance counters.

Parameters:
XLEN, 32, datapath width of alu_result_mem.
STALL_CYCLES, 1, cycles the front end is held per load-use hazard (legal 1..15).
CNT_W, 32, width of the performance counters.

Ports:
CLK  input  1  core clock, rising edge.
RESET_N  input  1  synchronous, active-low reset.
branch_mem  input  1  MEM-stage instruction is a conditional branch.
func3_mem  input  3  func3 of the MEM-stage instruction.
zero_mem  input  1  ALU zero flag of the MEM-stage instruction.
alu_result_mem  input  XLEN  ALU result of the MEM-stage instruction (SLT/SLTU for relational branches).
mem_read_ex  input  1  EX-stage instruction is a load.
rd_ex  input  5  destination register of the EX-stage instruction.
rs1_id, rs2_id  input  5 each  source registers of the ID-stage instruction.
rs1_used_id, rs2_used_id  input  1 each  ID-stage instruction reads rs1 / rs2.
pc_src  output  1  1 selects the branch target for the next PC.
pc_write_en  output  1  PC register enable.
if_id_write_en  output  1  IF/ID register enable.
if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load a bubble into that pipeline register.
stalling  output  1  controller is in STALL state (registered).
taken_count  output  CNT_W  number of taken branches.
stall_count  output  CNT_W  number of stall cycles issued.

Behaviour:
Branch resolution (combinational), taken = branch_mem AND cond:
- 000 BEQ: zero_mem.
- 001 BNE: !zero_mem.
- 100 BLT / 110 BLTU: alu_result_mem[0].
- 101 BGE / 111 BGEU: !alu_result_mem[0].
- 010 and 011: never taken.

Load-use hazard (combinational): hazard = mem_read_ex AND rd_ex != 0 AND ((rs1_used_id AND rs1_id == rd_ex) OR (rs2_used_id AND rs2_id == rd_ex)).

FSM states: IDLE, STALL. Holds a 4-bit stall counter scnt.

IDLE:
- If taken: pc_src=1; if_id_flush, id_ex_flush and ex_mem_flush all =1 in the same cycle (Mealy, zero latency). Next state IDLE. taken_count increments.
- Else if hazard: pc_write_en=0, if_id_write_en=0, id_ex_flush=1 in the same cycle. stall_count increments.
  - STALL_CYCLES==1: next state IDLE.
  - Otherwise: next state STALL, scnt = STALL_CYCLES-1.
- Else: defaults apply.

STALL (Moore):
- Outputs: pc_write_en=0, if_id_write_en=0, id_ex_flush=1. stall_count increments each cycle.
- scnt decrements each cycle; at scnt==1 the next state is IDLE.
- A taken branch in STALL aborts the stall. That cycle uses the IDLE-taken outputs, with pc_write_en=1 and if_id_write_en=1. No stall_count increment. Next state IDLE.

Defaults: pc_src=0, pc_write_en=1, if_id_write_en=1, all flushes 0.

Other rules:
- Precedence: taken beats hazard in the same cycle. No stall is issued and stall_count does not change.
- Total front-end hold per hazard is exactly STALL_CYCLES cycles unless aborted by a taken branch.
- Counters wrap modulo 2^CNT_W.
- stalling is 1 exactly while the state register is STALL.

Reset (RESET_N=0 sampled at the rising edge):
- State=IDLE, scnt=0, counters=0, stalling=0.
- While RESET_N is low, combinational outputs are forced to defaults regardless of inputs.
- Reset mid-STALL ends the stall on the next edge.

Test Plan:
1. BEQ, func3=000, zero=1 -> same-cycle pc_src=1 and all three flushes=1; taken_count 0->1. Then zero=0 -> pc_src=0.
2. BLT, alu_result[0]=1 -> taken. BGEU (111), alu_result[0]=1 -> not taken. func3=010 with branch=1 -> not taken, counters unchanged.
3. Load to x5 in EX, ID reads rs2=x5 with rs2_used=1, STALL_CYCLES=3 -> pc_write_en=0 for exactly 3 cycles and stalling=1 for the last 2; stall_count=3. Same with rd_ex=0 -> no stall.
4. Taken branch and hazard in the same cycle -> flush only, pc_write_en=1, stall_count unchanged.
5. STALL_CYCLES=4, taken branch in the 2nd stall cycle -> that cycle pc_src=1, flushes=1, pc_write_en=1; next cycle IDLE; stall_count=1.
6. RESET_N=0 for 1 cycle during STALL with counters nonzero -> after the edge: stalling=0, counters=0, outputs at defaults.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Branch resolution, PC redirect/squash and load-use stall control
//            for a 5-stage RISC-V pipeline, with taken/stall event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int XLEN         = 32,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             branch_mem,
    input  logic [2:0]       func3_mem,
    input  logic             zero_mem,
    input  logic [XLEN-1:0]  alu_result_mem,
    input  logic             mem_read_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    output logic             pc_src,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             stalling,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam logic [3:0] C_SCNT_LOAD = 4'(STALL_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_cond, w_taken, w_hazard;
    logic unused_alu_hi;

    // Relational branches arrive pre-reduced to SLT/SLTU, so only bit 0 matters.
    assign unused_alu_hi = ^alu_result_mem[XLEN-1:1];

    always_comb begin
        w_cond = 1'b0;
        case (func3_mem)
            3'b000:          w_cond = zero_mem;
            3'b001:          w_cond = ~zero_mem;
            3'b100, 3'b110:  w_cond = alu_result_mem[0];
            3'b101, 3'b111:  w_cond = ~alu_result_mem[0];
            default:         w_cond = 1'b0;
        endcase
    end

    assign w_taken  = branch_mem & w_cond;
    assign w_hazard = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    always_comb begin
        pc_src         = 1'b0;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        state_d        = state_q;
        scnt_d         = scnt_q;
        taken_cnt_d    = taken_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (RESET_N) begin
            if (w_taken) begin
                // A taken branch wins in either state and cancels any stall.
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                taken_cnt_d  = taken_cnt_q + CNT_W'(1);
                state_d      = ST_IDLE;
                scnt_d       = 4'd0;
            end else if (state_q == ST_STALL) begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_flush    = 1'b1;
                stall_cnt_d    = stall_cnt_q + CNT_W'(1);
                scnt_d         = scnt_q - 4'd1;
                if (scnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end else if (w_hazard) begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_flush    = 1'b1;
                stall_cnt_d    = stall_cnt_q + CNT_W'(1);
                if (STALL_CYCLES > 1) begin
                    state_d = ST_STALL;
                    scnt_d  = C_SCNT_LOAD;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            scnt_q      <= 4'd0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stalling    = (state_q == ST_STALL);
    assign taken_count = taken_cnt_q;
    assign stall_count = stall_cnt_q;

endmodule
`default_nettype wire
